servant_rst_seq: RTL and testbench

Reset sequencer between the SoC clock source (PLL) and the servant core. Holds peripheral and CPU resets asserted until the PLL lock indicator has been continuously high for a filter window, then waits a hold-off and releases the peripheral reset before the CPU reset. It re-enters reset on any loss of lock and records lock-loss events for debug.

---
 rtl/servant_rst_seq_pkg.sv | 26 ++
 rtl/servant_rst_seq_sync2.sv | 22 ++
 rtl/servant_rst_seq.sv | 171 +++++++++++++++++
 tb/tb_servant_rst_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/servant_rst_seq_pkg.sv
// Shared types and constants for the servant reset sequencer.
package servant_rst_seq_pkg;

    // Sequencer states; prefixed so they cannot collide with the STAGGER parameter.
    typedef enum logic [1:0] {
        ST_FILTER  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_STAGGER = 2'd2,
        ST_RUN     = 2'd3
    } seq_state_t;

    localparam int unsigned LOSS_CNT_W = 8;

    // Largest of three values, never below 2, so $clog2 of it yields a usable width.
    function automatic int unsigned max3_min2(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = 2;
        if (a > m) m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/servant_rst_seq_sync2.sv
// Two-flop synchronizer for a single asynchronous input, reset to 0.
module servant_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the async input through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/servant_rst_seq.sv
// Reset sequencer: filters PLL lock, then releases peripheral reset and,
// after a stagger, the CPU reset. Any lock loss re-enters reset.
// Optional LED status blinker enabled by SERVANT_RST_SEQ_STATUS_EN.
module servant_rst_seq
    import servant_rst_seq_pkg::*;
#(
    parameter int unsigned LOCK_FILT   = 16,
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter int unsigned STAGGER     = 8,
    parameter int unsigned BLINK_LOG2  = 22
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst_n,
    input  logic                  i_locked,
    output logic                  o_rst,
    output logic                  o_cpu_rst,
    output logic                  o_ready,
    output logic                  o_fault,
    output logic [LOSS_CNT_W-1:0] o_loss_cnt,
    output logic                  o_status
);

    localparam int unsigned CNT_W = $clog2(max3_min2(LOCK_FILT, HOLD_CYCLES, STAGGER));

    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'((STAGGER == 0) ? 0 : STAGGER - 1);

    if (LOCK_FILT < 1 || HOLD_CYCLES < 1 || BLINK_LOG2 < 3) begin : g_bad_param
        $error("servant_rst_seq: LOCK_FILT and HOLD_CYCLES must be >= 1, BLINK_LOG2 >= 3");
    end

    logic                  lock_s;
    seq_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rst_d, cpu_rst_d, ready_d, fault_d;
    logic [LOSS_CNT_W-1:0] loss_d;

    servant_sync2 u_lock_sync (
        .clk   (wb_clk),
        .rst_n (wb_rst_n),
        .d     (i_locked),
        .q     (lock_s)
    );

    // State, counter and all sequencer outputs are registered here.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q    <= ST_FILTER;
            cnt_q      <= '0;
            o_rst      <= 1'b1;
            o_cpu_rst  <= 1'b1;
            o_ready    <= 1'b0;
            o_fault    <= 1'b0;
            o_loss_cnt <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            o_rst      <= rst_d;
            o_cpu_rst  <= cpu_rst_d;
            o_ready    <= ready_d;
            o_fault    <= fault_d;
            o_loss_cnt <= loss_d;
        end
    end

    // Next-state and next-output logic; lock loss outside FILTER overrides everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rst_d     = o_rst;
        cpu_rst_d = o_cpu_rst;
        ready_d   = o_ready;
        fault_d   = o_fault;
        loss_d    = o_loss_cnt;

        case (state_q)
            ST_FILTER: begin
                if (!lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == FILT_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    rst_d = 1'b0;
                    if (STAGGER == 0) begin
                        state_d   = ST_RUN;
                        cpu_rst_d = 1'b0;
                        ready_d   = 1'b1;
                    end else begin
                        state_d = ST_STAGGER;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STAGGER: begin
                if (cnt_q == STAG_LAST) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    cpu_rst_d = 1'b0;
                    ready_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_FILTER;
                cnt_d   = '0;
            end
        endcase

        if (state_q != ST_FILTER && !lock_s) begin
            state_d   = ST_FILTER;
            cnt_d     = '0;
            rst_d     = 1'b1;
            cpu_rst_d = 1'b1;
            ready_d   = 1'b0;
            if (o_loss_cnt != '1) begin
                loss_d = o_loss_cnt + LOSS_CNT_W'(1);
            end
            if (state_q == ST_RUN) begin
                fault_d = 1'b1;
            end
        end
    end

`ifdef SERVANT_RST_SEQ_STATUS_EN
    logic [BLINK_LOG2-1:0] blink_q;
    logic                  status_q;
    logic                  slow_tick;
    logic                  fast_tick;

    assign slow_tick = &blink_q;
    assign fast_tick = &blink_q[BLINK_LOG2-3:0];

    // Free-running blink counter; slow blink while sequencing, steady on in
    // healthy RUN, fast blink in RUN after a fault.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            blink_q  <= '0;
            status_q <= 1'b0;
        end else begin
            blink_q <= blink_q + BLINK_LOG2'(1);
            if (state_q == ST_RUN) begin
                if (!o_fault) begin
                    status_q <= 1'b1;
                end else if (fast_tick) begin
                    status_q <= ~status_q;
                end
            end else if (slow_tick) begin
                status_q <= ~status_q;
            end
        end
    end

    assign o_status = status_q;
`else
    assign o_status = 1'b0;
`endif

endmodule

// File: tb/tb_servant_rst_seq.sv
// Scoreboard bench for servant_rst_seq: two instances (STAGGER=3 and STAGGER=0)
// share lock and reset stimulus; a negedge monitor pops expected output events.
module tb_servant_rst_seq;

    typedef struct packed {
        logic       rst;
        logic       cpu;
        logic       rdy;
        logic       flt;
        logic [7:0] cnt;
    } obs_t;

    typedef struct packed {
        logic [31:0] cyc;
        obs_t        o;
    } exp_t;

    localparam logic [31:0] ANY = '1;

    logic clk = 1'b0;
    logic wb_rst_n;
    logic i_locked;

    logic       a_rst, a_cpu, a_rdy, a_flt, a_status;
    logic [7:0] a_cnt;
    logic       b_rst, b_cpu, b_rdy, b_flt, b_status;
    logic [7:0] b_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;

    exp_t qa[$];
    exp_t qb[$];
    obs_t last_a, last_b, oa, ob;
    exp_t ea, eb;

    int unsigned st_mode     = 0;
    logic        st_prev;
    logic        st_seen     = 1'b0;
    logic        st_tog_seen = 1'b0;
    int unsigned st_last     = 0;
    int unsigned tog1        = 0;
    int unsigned tog3        = 0;

    servant_rst_seq #(
        .LOCK_FILT   (4),
        .HOLD_CYCLES (10),
        .STAGGER     (3),
        .BLINK_LOG2  (3)
    ) u_a (
        .wb_clk     (clk),
        .wb_rst_n   (wb_rst_n),
        .i_locked   (i_locked),
        .o_rst      (a_rst),
        .o_cpu_rst  (a_cpu),
        .o_ready    (a_rdy),
        .o_fault    (a_flt),
        .o_loss_cnt (a_cnt),
        .o_status   (a_status)
    );

    servant_rst_seq #(
        .LOCK_FILT   (4),
        .HOLD_CYCLES (10),
        .STAGGER     (0),
        .BLINK_LOG2  (3)
    ) u_b (
        .wb_clk     (clk),
        .wb_rst_n   (wb_rst_n),
        .i_locked   (i_locked),
        .o_rst      (b_rst),
        .o_cpu_rst  (b_cpu),
        .o_ready    (b_rdy),
        .o_fault    (b_flt),
        .o_loss_cnt (b_cnt),
        .o_status   (b_status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic exp_t mk(input int unsigned c, input logic r, input logic cp,
                                input logic rd, input logic f, input logic [7:0] n);
        exp_t e;
        e.cyc = c;
        e.o   = {r, cp, rd, f, n};
        return e;
    endfunction

    task automatic chk_reset(input string tag);
        check({tag, "_a"}, {19'd0, a_rst, a_cpu, a_rdy, a_flt, a_cnt, a_status},
              {19'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
        check({tag, "_b"}, {19'd0, b_rst, b_cpu, b_rdy, b_flt, b_cnt, b_status},
              {19'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
    endtask

    // Monitor: every output change must match the next queued event and cycle.
    always @(negedge clk) begin
        oa = {a_rst, a_cpu, a_rdy, a_flt, a_cnt};
        ob = {b_rst, b_cpu, b_rdy, b_flt, b_cnt};
        if (oa !== last_a) begin
            if (qa.size() == 0) begin
                check("a_unexpected_change", {20'd0, oa}, {20'd0, last_a});
            end else begin
                ea = qa.pop_front();
                check("a_outputs", {20'd0, oa}, {20'd0, ea.o});
                if (ea.cyc != ANY) check("a_event_cycle", cyc, ea.cyc);
            end
        end
        if (ob !== last_b) begin
            if (qb.size() == 0) begin
                check("b_unexpected_change", {20'd0, ob}, {20'd0, last_b});
            end else begin
                eb = qb.pop_front();
                check("b_outputs", {20'd0, ob}, {20'd0, eb.o});
                if (eb.cyc != ANY) check("b_event_cycle", cyc, eb.cyc);
            end
        end
        last_a = oa;
        last_b = ob;
        if (a_rst) check("a_cpu_rst_order", {31'd0, a_cpu}, 32'd1);
        if (b_rst) check("b_cpu_rst_order", {31'd0, b_cpu}, 32'd1);

        if (st_mode != 0) begin
`ifdef SERVANT_RST_SEQ_STATUS_EN
            if (st_mode == 2) begin
                check("status_run_steady", {31'd0, a_status}, 32'd1);
            end else begin
                if (st_seen && a_status != st_prev) begin
                    if (st_tog_seen) check("status_period", cyc - st_last, (st_mode == 1) ? 32'd8 : 32'd2);
                    st_last     = cyc;
                    st_tog_seen = 1'b1;
                    if (st_mode == 1) tog1++;
                    else tog3++;
                end
                st_prev = a_status;
                st_seen = 1'b1;
            end
`else
            check("status_tied_low", {31'd0, a_status}, 32'd0);
`endif
        end else begin
            st_seen     = 1'b0;
            st_tog_seen = 1'b0;
        end
    end

    initial begin
        int unsigned c;
        wb_rst_n = 1'b1;
        i_locked = 1'b0;
        qa.push_back(mk(ANY, 1, 1, 0, 0, 8'd0));
        qb.push_back(mk(ANY, 1, 1, 0, 0, 8'd0));
        #1 wb_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("por");
        wb_rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Glitch: 3 cycles high (one short of the filter), then low, then stable.
        i_locked = 1'b1;
        repeat (3) @(negedge clk);
        i_locked = 1'b0;
        repeat (6) @(negedge clk);

        // Clean lock rise: release 16 and 19 cycles after the driving negedge.
        c = cyc;
        i_locked = 1'b1;
        qa.push_back(mk(c + 16, 0, 1, 0, 0, 8'd0));
        qa.push_back(mk(c + 19, 0, 0, 1, 0, 8'd0));
        qb.push_back(mk(c + 16, 0, 0, 1, 0, 8'd0));
        repeat (21) @(negedge clk);
        st_mode = 2;
        repeat (4) @(negedge clk);
        st_mode = 0;

        // One-cycle lock loss in RUN: fault, count 1, full re-sequence.
        c = cyc;
        i_locked = 1'b0;
        qa.push_back(mk(c + 3, 1, 1, 0, 1, 8'd1));
        qb.push_back(mk(c + 3, 1, 1, 0, 1, 8'd1));
        @(negedge clk);
        i_locked = 1'b1;
        qa.push_back(mk(c + 17, 0, 1, 0, 1, 8'd1));
        qa.push_back(mk(c + 20, 0, 0, 1, 1, 8'd1));
        qb.push_back(mk(c + 17, 0, 0, 1, 1, 8'd1));
        repeat (20) @(negedge clk);
        st_mode = 3;
        repeat (19) @(negedge clk);
        st_mode = 0;

        // Asynchronous reset mid-RUN.
        c = cyc;
        #2 wb_rst_n = 1'b0;
        #1 chk_reset("async_run");
        qa.push_back(mk(c + 1, 1, 1, 0, 0, 8'd0));
        qb.push_back(mk(c + 1, 1, 1, 0, 0, 8'd0));
        @(negedge clk);
        @(negedge clk);
        wb_rst_n = 1'b1;
        c = cyc;

        // Lock loss in HOLD (HOLD entered 6 cycles after release).
        repeat (8) @(negedge clk);
        i_locked = 1'b0;
        qa.push_back(mk(c + 11, 1, 1, 0, 0, 8'd1));
        qb.push_back(mk(c + 11, 1, 1, 0, 0, 8'd1));
        @(negedge clk);
        i_locked = 1'b1;
        qa.push_back(mk(c + 25, 0, 1, 0, 0, 8'd1));
        qa.push_back(mk(c + 28, 0, 0, 1, 0, 8'd1));
        qb.push_back(mk(c + 25, 0, 0, 1, 0, 8'd1));
        repeat (21) @(negedge clk);

        // Reset again, then 300 lock losses in HOLD to saturate the counter.
        c = cyc;
        #2 wb_rst_n = 1'b0;
        #1 chk_reset("async_hold");
        qa.push_back(mk(c + 1, 1, 1, 0, 0, 8'd0));
        qb.push_back(mk(c + 1, 1, 1, 0, 0, 8'd0));
        @(negedge clk);
        @(negedge clk);
        wb_rst_n = 1'b1;
        st_mode = 1;
        for (int k = 1; k <= 300; k++) begin
            repeat (6) @(negedge clk);
            c = cyc;
            i_locked = 1'b0;
            if (k <= 255) begin
                qa.push_back(mk(c + 3, 1, 1, 0, 0, 8'(k)));
                qb.push_back(mk(c + 3, 1, 1, 0, 0, 8'(k)));
            end
            @(negedge clk);
            i_locked = 1'b1;
        end
        st_mode = 0;
        c = cyc;
        qa.push_back(mk(c + 16, 0, 1, 0, 0, 8'd255));
        qa.push_back(mk(c + 19, 0, 0, 1, 0, 8'd255));
        qb.push_back(mk(c + 16, 0, 0, 1, 0, 8'd255));
        repeat (25) @(negedge clk);
        check("a_loss_saturated", {24'd0, a_cnt}, 32'd255);
        check("b_loss_saturated", {24'd0, b_cnt}, 32'd255);

`ifdef SERVANT_RST_SEQ_STATUS_EN
        check("status_slow_toggled", {31'd0, tog1 > 1}, 32'd1);
        check("status_fast_toggled", {31'd0, tog3 > 1}, 32'd1);
`endif

        while (qa.size() > 0) begin
            ea = qa.pop_front();
            check("a_missing_event", {20'd0, last_a}, {20'd0, ea.o});
        end
        while (qb.size() > 0) begin
            eb = qb.pop_front();
            check("b_missing_event", {20'd0, last_b}, {20'd0, eb.o});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
